// File: rtl/zxiznet_pkg.sv
// Shared definitions for the ZXiznet CPLD: the card's I/O port and the
// Z80 I/O-cycle state encoding.
`timescale 1ns/1ps
package zxiznet_pkg;

  localparam logic [7:0] PORT_LO_DEF = 8'hAB;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_QUAL = 2'd1,
    ST_ACC  = 2'd2,
    ST_WAIT = 2'd3
  } zbus_state_e;

endpackage

// File: rtl/zbus_sync.sv
// Multi-flop synchronizer for one asynchronous Z80 strobe. The reset value is
// 1 because every Z80 strobe is active low, so reset means "inactive".
`timescale 1ns/1ps
module zbus_sync #(
  parameter int LEN = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [LEN-1:0] sh_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sh_q <= '1;
    else        sh_q <= {sh_q[LEN-2:0], d};
  end

  assign q = sh_q[LEN-1];

endmodule

// File: rtl/zbus_io_cycle.sv
// Z80 I/O cycle front end: synchronizes the Z80 strobes, qualifies accesses to
// the card's port and emits one rd/wr strobe per Z80 I/O cycle.
`timescale 1ns/1ps
module zbus_io_cycle
  import zxiznet_pkg::*;
#(
  parameter logic [7:0] PORT_LO    = PORT_LO_DEF,
  parameter int         SYNC_LEN   = 2,
  parameter int         STABLE_LEN = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] za,
  input  logic [7:0]  zd_in,
  input  logic        ziorq_n,
  input  logic        zrd_n,
  input  logic        zwr_n,
  input  logic        zm1_n,
  output logic        ziorqge,
  output logic [7:0]  reg_idx,
  output logic [7:0]  wdata,
  output logic        wr_stb,
  output logic        rd_stb,
  output logic        busy
);

  localparam int CNT_W = $clog2(STABLE_LEN + 1);

  logic iorq_s, rd_s, wr_s, m1_s;
  logic port_hit, hit_rd, hit_wr, same_hit;

  zbus_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_wr_q, is_wr_d;
  logic [7:0]       reg_idx_q, reg_idx_d;
  logic [7:0]       wdata_q, wdata_d;

  zbus_sync #(.LEN(SYNC_LEN)) u_sync_iorq (.clk(clk), .rst_n(rst_n), .d(ziorq_n), .q(iorq_s));
  zbus_sync #(.LEN(SYNC_LEN)) u_sync_rd   (.clk(clk), .rst_n(rst_n), .d(zrd_n),   .q(rd_s));
  zbus_sync #(.LEN(SYNC_LEN)) u_sync_wr   (.clk(clk), .rst_n(rst_n), .d(zwr_n),   .q(wr_s));
  zbus_sync #(.LEN(SYNC_LEN)) u_sync_m1   (.clk(clk), .rst_n(rst_n), .d(zm1_n),   .q(m1_s));

  // The Z80 holds the address stable for the whole strobe, so it is decoded unsynchronized.
  assign port_hit = (za[7:0] == PORT_LO);
  assign hit_rd   = ~iorq_s & ~rd_s & m1_s & port_hit;
  assign hit_wr   = ~iorq_s & ~wr_s & m1_s & port_hit;
  assign same_hit = is_wr_q ? hit_wr : hit_rd;

  // ziorqge must follow the bus with no clock delay.
  assign ziorqge = ~ziorq_n & zm1_n & ~zrd_n & port_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      is_wr_q   <= 1'b0;
      reg_idx_q <= 8'h00;
      wdata_q   <= 8'h00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_wr_q   <= is_wr_d;
      reg_idx_q <= reg_idx_d;
      wdata_q   <= wdata_d;
    end
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_wr_d   = is_wr_q;
    reg_idx_d = reg_idx_q;
    wdata_d   = wdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (hit_rd) begin
          state_d = ST_QUAL;
          cnt_d   = CNT_W'(1);
          is_wr_d = 1'b0;
        end else if (hit_wr) begin
          state_d = ST_QUAL;
          cnt_d   = CNT_W'(1);
          is_wr_d = 1'b1;
        end
      end
      ST_QUAL: begin
        if (!same_hit) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_W'(STABLE_LEN)) begin
          // Latch on entry so index and data are valid alongside the strobe.
          state_d   = ST_ACC;
          reg_idx_d = za[15:8];
          if (is_wr_q) wdata_d = zd_in;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_ACC:  state_d = ST_WAIT;
      ST_WAIT: if (iorq_s && rd_s && wr_s) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wr_stb = (state_q == ST_ACC) &&  is_wr_q;
    rd_stb = (state_q == ST_ACC) && !is_wr_q;
    busy   = (state_q == ST_ACC) || (state_q == ST_WAIT);
  end

  assign reg_idx = reg_idx_q;
  assign wdata   = wdata_q;

endmodule

// File: tb/tb_zbus_io_cycle.sv
// Directed bench for zbus_io_cycle: Z80 I/O reads, writes, misses, glitches,
// back-to-back cycles and reset in the middle of a cycle.
`timescale 1ns/1ps
module tb_zbus_io_cycle;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] za = 16'h0000;
  logic [7:0]  zd_in = 8'h00;
  logic        ziorq_n = 1'b1, zrd_n = 1'b1, zwr_n = 1'b1, zm1_n = 1'b1;
  logic        ziorqge, wr_stb, rd_stb, busy;
  logic [7:0]  reg_idx, wdata;

  int n_vec = 0;
  int n_err = 0;

  int unsigned wr_seen = 0;
  int unsigned rd_seen = 0;
  logic [7:0]  wr_idx_log [16];
  logic [7:0]  wr_dat_log [16];

  zbus_io_cycle dut (
    .clk(clk), .rst_n(rst_n), .za(za), .zd_in(zd_in),
    .ziorq_n(ziorq_n), .zrd_n(zrd_n), .zwr_n(zwr_n), .zm1_n(zm1_n),
    .ziorqge(ziorqge), .reg_idx(reg_idx), .wdata(wdata),
    .wr_stb(wr_stb), .rd_stb(rd_stb), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_stb) begin
      wr_idx_log[wr_seen[3:0]] = reg_idx;
      wr_dat_log[wr_seen[3:0]] = wdata;
      wr_seen++;
    end
    if (rd_stb) rd_seen++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t required < 200000", $time);
    $fatal(1);
  end

  task automatic bus_start(input logic is_wr, input logic [15:0] addr,
                           input logic [7:0] data, input logic m1_low);
    @(posedge clk); #2;
    za = addr; zd_in = data; zm1_n = ~m1_low; ziorq_n = 1'b0;
    if (is_wr) zwr_n = 1'b0; else zrd_n = 1'b0;
  endtask

  task automatic bus_idle();
    @(posedge clk); #2;
    ziorq_n = 1'b1; zrd_n = 1'b1; zwr_n = 1'b1; zm1_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++; if (wr_stb !== 1'b0)   begin n_err++; $display("FAIL reset_wr_stb: got %b want 0", wr_stb); end
    n_vec++; if (rd_stb !== 1'b0)   begin n_err++; $display("FAIL reset_rd_stb: got %b want 0", rd_stb); end
    n_vec++; if (busy !== 1'b0)     begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_vec++; if (reg_idx !== 8'h00) begin n_err++; $display("FAIL reset_reg_idx: got %h want 00", reg_idx); end
    n_vec++; if (wdata !== 8'h00)   begin n_err++; $display("FAIL reset_wdata: got %h want 00", wdata); end
    @(posedge clk); #2; rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_write();
    int unsigned w0 = wr_seen, r0 = rd_seen;
    bus_start(1'b1, 16'h05AB, 8'h3C, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    n_vec++; if (wr_stb !== 1'b0) begin n_err++; $display("FAIL wr_early: got %b want 0", wr_stb); end
    @(negedge clk);
    n_vec++; if (wr_stb !== 1'b1)   begin n_err++; $display("FAIL wr_latency: got %b want 1", wr_stb); end
    n_vec++; if (reg_idx !== 8'h05) begin n_err++; $display("FAIL wr_reg_idx: got %h want 05", reg_idx); end
    n_vec++; if (wdata !== 8'h3C)   begin n_err++; $display("FAIL wr_wdata: got %h want 3c", wdata); end
    n_vec++; if (rd_stb !== 1'b0)   begin n_err++; $display("FAIL wr_rd_stb: got %b want 0", rd_stb); end
    @(negedge clk);
    n_vec++; if (wr_stb !== 1'b0) begin n_err++; $display("FAIL wr_pulse_width: got %b want 0", wr_stb); end
    n_vec++; if (busy !== 1'b1)   begin n_err++; $display("FAIL wr_busy_hold: got %b want 1", busy); end
    repeat (10) @(posedge clk);
    bus_idle();
    repeat (5) @(posedge clk);
    @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL wr_busy_release: got %b want 0", busy); end
    n_vec++; if (wr_seen - w0 !== 32'd1) begin n_err++; $display("FAIL wr_count: got %0d want 1", wr_seen - w0); end
    n_vec++; if (rd_seen - r0 !== 32'd0) begin n_err++; $display("FAIL wr_rd_count: got %0d want 0", rd_seen - r0); end
  endtask

  task automatic test_read();
    int unsigned w0 = wr_seen, r0 = rd_seen;
    bus_start(1'b0, 16'h12AB, 8'h00, 1'b0);
    #1;
    n_vec++; if (ziorqge !== 1'b1) begin n_err++; $display("FAIL rd_ziorqge_on: got %b want 1", ziorqge); end
    repeat (8) @(posedge clk);
    @(negedge clk);
    n_vec++; if (ziorqge !== 1'b1)  begin n_err++; $display("FAIL rd_ziorqge_hold: got %b want 1", ziorqge); end
    n_vec++; if (busy !== 1'b1)     begin n_err++; $display("FAIL rd_busy: got %b want 1", busy); end
    n_vec++; if (reg_idx !== 8'h12) begin n_err++; $display("FAIL rd_reg_idx: got %h want 12", reg_idx); end
    bus_idle();
    #1;
    n_vec++; if (ziorqge !== 1'b0) begin n_err++; $display("FAIL rd_ziorqge_off: got %b want 0", ziorqge); end
    repeat (5) @(posedge clk);
    @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rd_busy_release: got %b want 0", busy); end
    n_vec++; if (rd_seen - r0 !== 32'd1) begin n_err++; $display("FAIL rd_count: got %0d want 1", rd_seen - r0); end
    n_vec++; if (wr_seen - w0 !== 32'd0) begin n_err++; $display("FAIL rd_wr_count: got %0d want 0", wr_seen - w0); end
  endtask

  task automatic test_miss_inta();
    int unsigned w0 = wr_seen, r0 = rd_seen;
    bus_start(1'b1, 16'h05AC, 8'h55, 1'b0);
    repeat (8) @(posedge clk);
    @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL miss_busy: got %b want 0", busy); end
    bus_idle();
    repeat (5) @(posedge clk);
    bus_start(1'b0, 16'h00AB, 8'h00, 1'b1);
    #1;
    n_vec++; if (ziorqge !== 1'b0) begin n_err++; $display("FAIL inta_ziorqge: got %b want 0", ziorqge); end
    repeat (8) @(posedge clk);
    @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL inta_busy: got %b want 0", busy); end
    bus_idle();
    repeat (5) @(posedge clk);
    @(negedge clk);
    n_vec++; if (wr_seen - w0 !== 32'd0) begin n_err++; $display("FAIL miss_wr_count: got %0d want 0", wr_seen - w0); end
    n_vec++; if (rd_seen - r0 !== 32'd0) begin n_err++; $display("FAIL miss_rd_count: got %0d want 0", rd_seen - r0); end
    n_vec++; if (reg_idx !== 8'h12) begin n_err++; $display("FAIL miss_reg_idx_hold: got %h want 12", reg_idx); end
  endtask

  task automatic test_glitch();
    int unsigned w0 = wr_seen;
    bus_start(1'b1, 16'h07AB, 8'h99, 1'b0);
    @(posedge clk); #2; zwr_n = 1'b1;
    repeat (3) @(posedge clk);
    bus_idle();
    repeat (6) @(posedge clk);
    @(negedge clk);
    n_vec++; if (wr_seen - w0 !== 32'd0) begin n_err++; $display("FAIL glitch_wr_count: got %0d want 0", wr_seen - w0); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL glitch_busy: got %b want 0", busy); end
    bus_start(1'b1, 16'h07AB, 8'h5A, 1'b0);
    repeat (21) @(posedge clk);
    bus_idle();
    repeat (6) @(posedge clk);
    @(negedge clk);
    n_vec++; if (wr_seen - w0 !== 32'd1) begin n_err++; $display("FAIL wait_wr_count: got %0d want 1", wr_seen - w0); end
    n_vec++; if (wdata !== 8'h5A)   begin n_err++; $display("FAIL wait_wdata: got %h want 5a", wdata); end
    n_vec++; if (reg_idx !== 8'h07) begin n_err++; $display("FAIL wait_reg_idx: got %h want 07", reg_idx); end
  endtask

  task automatic test_back_to_back();
    int unsigned w0 = wr_seen;
    logic [3:0] i0, i1;
    i0 = w0[3:0];
    i1 = i0 + 4'd1;
    bus_start(1'b1, 16'hFFAB, 8'h01, 1'b0);
    repeat (8) @(posedge clk);
    bus_idle();
    repeat (2) @(posedge clk);
    bus_start(1'b1, 16'h00AB, 8'h02, 1'b0);
    repeat (8) @(posedge clk);
    bus_idle();
    repeat (6) @(posedge clk);
    @(negedge clk);
    n_vec++; if (wr_seen - w0 !== 32'd2) begin n_err++; $display("FAIL b2b_count: got %0d want 2", wr_seen - w0); end
    n_vec++; if (wr_idx_log[i0] !== 8'hFF || wr_dat_log[i0] !== 8'h01)
      begin n_err++; $display("FAIL b2b_first: got %h/%h want ff/01", wr_idx_log[i0], wr_dat_log[i0]); end
    n_vec++; if (wr_idx_log[i1] !== 8'h00 || wr_dat_log[i1] !== 8'h02)
      begin n_err++; $display("FAIL b2b_second: got %h/%h want 00/02", wr_idx_log[i1], wr_dat_log[i1]); end
  endtask

  task automatic test_reset_mid();
    int unsigned w1;
    bit in_wait = 1'b0;
    bus_start(1'b1, 16'h33AB, 8'hC7, 1'b0);
    for (int i = 0; i < 20 && !in_wait; i++) begin
      @(negedge clk);
      if (busy && !wr_stb) in_wait = 1'b1;
    end
    n_vec++; if (!in_wait) begin n_err++; $display("FAIL rst_mid_reach_wait: got timeout want busy within 20 clks"); end
    @(posedge clk); #2; rst_n = 1'b0;
    #1;
    n_vec++; if (busy !== 1'b0 || wr_stb !== 1'b0 || rd_stb !== 1'b0)
      begin n_err++; $display("FAIL rst_mid_ctrl: got busy=%b wr=%b rd=%b want 0/0/0", busy, wr_stb, rd_stb); end
    n_vec++; if (reg_idx !== 8'h00 || wdata !== 8'h00)
      begin n_err++; $display("FAIL rst_mid_data: got %h/%h want 00/00", reg_idx, wdata); end
    repeat (2) @(posedge clk);
    w1 = wr_seen;
    #2; rst_n = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    n_vec++; if (wr_stb !== 1'b0) begin n_err++; $display("FAIL rst_rel_early: got %b want 0", wr_stb); end
    @(negedge clk);
    n_vec++; if (wr_stb !== 1'b1 || reg_idx !== 8'h33 || wdata !== 8'hC7)
      begin n_err++; $display("FAIL rst_rel_strobe: got %b %h/%h want 1 33/c7", wr_stb, reg_idx, wdata); end
    repeat (4) @(posedge clk);
    bus_idle();
    repeat (6) @(posedge clk);
    @(negedge clk);
    n_vec++; if (wr_seen - w1 !== 32'd1) begin n_err++; $display("FAIL rst_rel_count: got %0d want 1", wr_seen - w1); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_rel_busy: got %b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_miss_inta();
    test_glitch();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
